// File: rtl/rfrom_clk_switch_ctrl.sv
// Sequencer for the ROM glitch-free clock mux select: drains ROM accesses, flips clock_sel,
// waits out the mux settle window, then re-enables and acks. Optional post-switch
// hold-off is enabled by defining RFROM_CLKSW_DWELL_EN.
module rfrom_clk_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DWELL_CYCLES  = 32,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_req,
  input  logic sw_sel,
  output logic sw_ack,
  output logic clock_sel,
  output logic gate_en,
  output logic busy
);

  localparam int unsigned MAX_CNT = (32'd1 << CNT_W) - 32'd1;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_CNT ||
      DWELL_CYCLES < 1 || DWELL_CYCLES > MAX_CNT) begin : g_param_check
    $error("rfrom_clk_switch_ctrl: SETTLE_CYCLES/DWELL_CYCLES out of counter range");
  end

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRAIN0,
    ST_DRAIN1,
    ST_SWITCH,
    ST_RESUME
`ifdef RFROM_CLKSW_DWELL_EN
    , ST_DWELL
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             sw_ack_d, clock_sel_d, gate_en_d, busy_d;
`ifdef RFROM_CLKSW_DWELL_EN
  logic             toggle_q, toggle_d;
`endif

  // State, counter and outputs; outputs follow the state they were decoded from by one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
      sel_q     <= 1'b0;
      sw_ack    <= 1'b0;
      clock_sel <= 1'b0;
      gate_en   <= 1'b0;
      busy      <= 1'b1;
`ifdef RFROM_CLKSW_DWELL_EN
      toggle_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      sw_ack    <= sw_ack_d;
      clock_sel <= clock_sel_d;
      gate_en   <= gate_en_d;
      busy      <= busy_d;
`ifdef RFROM_CLKSW_DWELL_EN
      toggle_q  <= toggle_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    sw_ack_d    = 1'b0;
    clock_sel_d = clock_sel;
    gate_en_d   = 1'b0;
    busy_d      = 1'b1;
`ifdef RFROM_CLKSW_DWELL_EN
    toggle_d    = toggle_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
        gate_en_d = 1'b1;
        busy_d    = 1'b0;
        if (sw_req) begin
          sel_d = sw_sel;
          // Same source requested: acknowledge without touching the mux
          if (sw_sel != clock_sel) state_d = ST_DRAIN0;
          else                     state_d = ST_RESUME;
`ifdef RFROM_CLKSW_DWELL_EN
          toggle_d = (sw_sel != clock_sel);
`endif
        end
      end
      ST_DRAIN0: state_d = ST_DRAIN1;
      ST_DRAIN1: begin
        state_d = ST_SWITCH;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
      end
      ST_SWITCH: begin
        clock_sel_d = sel_q;
        if (cnt_q == '0) state_d = ST_RESUME;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESUME: begin
        sw_ack_d  = 1'b1;
        gate_en_d = 1'b1;
        state_d   = ST_IDLE;
`ifdef RFROM_CLKSW_DWELL_EN
        if (toggle_q) begin
          state_d = ST_DWELL;
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
        end
`endif
      end
`ifdef RFROM_CLKSW_DWELL_EN
      ST_DWELL: begin
        gate_en_d = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_rfrom_clk_switch_ctrl.sv
// Randomized scoreboard bench for rfrom_clk_switch_ctrl: the driver predicts per-cycle
// gate/busy/select values and ack events from the timing rules; a negedge monitor checks them.
module tb_rfrom_clk_switch_ctrl;

  localparam int S  = 16;
  localparam int DC = 32;
`ifdef RFROM_CLKSW_DWELL_EN
  localparam int DW = DC;
`else
  localparam int DW = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_req = 1'b0;
  logic sw_sel = 1'b0;
  logic sw_ack, clock_sel, gate_en, busy;

  rfrom_clk_switch_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(DC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_sel(sw_sel),
    .sw_ack(sw_ack), .clock_sel(clock_sel), .gate_en(gate_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  typedef struct { int cyc; bit csel; } ack_t;
  ack_t ack_q[$];
  bit   exp_gate[int];
  bit   exp_busy[int];
  bit   exp_csel[int];
  bit   model_csel = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, tcyc, act, exp);
    end
  endtask

  // Reference: timing of one accepted request at edge e, from the switch rules
  task automatic expect_txn(input int e, input bit sel);
    bit tog;
    tog = (sel != model_csel);
    exp_csel[e+1] = model_csel;
    exp_csel[e+2] = model_csel;
    if (tog) begin
      for (int c = e + 1; c <= e + 2 + S; c++) exp_gate[c] = 1'b0;
      for (int c = e + 1; c <= e + 3 + S + DW; c++) exp_busy[c] = 1'b1;
      for (int c = e + 3 + S; c <= e + 4 + S + DW; c++) exp_gate[c] = 1'b1;
      for (int c = e + 3; c <= e + 3 + S; c++) exp_csel[c] = sel;
      exp_busy[e+4+S+DW] = 1'b0;
      ack_q.push_back('{cyc: e + 3 + S, csel: sel});
    end else begin
      exp_gate[e+1] = 1'b1;
      exp_gate[e+2] = 1'b1;
      exp_busy[e+1] = 1'b1;
      exp_busy[e+2] = 1'b0;
      ack_q.push_back('{cyc: e + 1, csel: sel});
    end
    model_csel = sel;
  endtask

  task automatic expect_reset_release(input int base);
    for (int k = 1; k <= S; k++) begin
      exp_gate[base+k] = 1'b0;
      exp_busy[base+k] = 1'b1;
      exp_csel[base+k] = 1'b0;
    end
    exp_gate[base+S+1] = 1'b1;
    exp_busy[base+S+1] = 1'b0;
    exp_csel[base+S+1] = 1'b0;
  endtask

  task automatic raise(input bit sel, output int e);
    @(posedge clk); #1;
    sw_req = 1'b1;
    sw_sel = sel;
    e = tcyc + 1;
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sw_ack === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin seen = 1'b1; break; end
    end
    if (!seen) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares predicted per-cycle values and ack events
  logic prev_csel = 1'b0, prev_gate = 1'b0, prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_gate.exists(tcyc)) begin chk("gate_en", gate_en, exp_gate[tcyc]); exp_gate.delete(tcyc); end
      if (exp_busy.exists(tcyc)) begin chk("busy", busy, exp_busy[tcyc]); exp_busy.delete(tcyc); end
      if (exp_csel.exists(tcyc)) begin chk("clock_sel", clock_sel, exp_csel[tcyc]); exp_csel.delete(tcyc); end
      if (clock_sel !== prev_csel) chk("sel_change_gated", {prev_gate, gate_en}, 32'd0);
      if (sw_ack === 1'b1) begin
        chk("ack_single_pulse", prev_ack, 32'd0);
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          ack_t a;
          a = ack_q.pop_front();
          chk("ack_cycle", tcyc, a.cyc);
          chk("ack_clock_sel", clock_sel, a.csel);
          chk("ack_gate_en", gate_en, 32'd1);
        end
      end
    end
    prev_csel = clock_sel;
    prev_gate = gate_en;
    prev_ack  = sw_ack;
  end

  initial begin
    int e, e2;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_clock_sel", clock_sel, 32'd0);
    chk("rst_gate_en", gate_en, 32'd0);
    chk("rst_busy", busy, 32'd1);
    chk("rst_sw_ack", sw_ack, 32'd0);
    expect_reset_release(tcyc);
    rst = 1'b0;
    wait_idle();

    // 0->1 switch, request held through ack with target flipped back to 0
    raise(1'b1, e);
    expect_txn(e, 1'b1);
    wait_ack("held_first");
    sw_sel = 1'b0;
    expect_txn(e + 4 + S + DW, 1'b0);
    wait_ack("held_second");
    sw_req = 1'b0;
    wait_idle();

    // No-op request
    raise(1'b0, e);
    expect_txn(e, 1'b0);
    wait_ack("noop");
    sw_req = 1'b0;
    wait_idle();

    // Reset mid-SWITCH aborts without ack
    raise(1'b1, e);
    for (int c = e + 1; c <= e + 9; c++) begin
      exp_gate[c] = 1'b0;
      exp_busy[c] = 1'b1;
      exp_csel[c] = (c >= e + 3);
    end
    for (int i = 0; i < 50 && tcyc < e + 10; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    sw_req = 1'b0;
    #1;
    chk("abort_clock_sel", clock_sel, 32'd0);
    chk("abort_gate_en", gate_en, 32'd0);
    chk("abort_busy", busy, 32'd1);
    @(posedge clk); #2;
    model_csel = 1'b0;
    expect_reset_release(tcyc);
    rst = 1'b0;
    wait_idle();

    // Randomized requests
    for (int n = 0; n < 24; n++) begin
      bit sel;
      sel = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      raise(sel, e2);
      expect_txn(e2, sel);
      wait_ack("random");
      sw_req = 1'b0;
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("ack_queue_drained", ack_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
